// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
// Provides the operation encoding seen on the op port, the controller
// state encoding, and the number of shift/add or shift/subtract
// iterations needed for one full operation.
package muldiv_pkg;

  // Operation codes as presented on the op port by the decoder.
  typedef enum logic [1:0] {
    MULT  = 2'd0,
    MULTU = 2'd1,
    DIV   = 2'd2,
    DIVU  = 2'd3
  } muldiv_op_t;

  // Controller states: waiting, iterating, committing the result.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC   = 2'd1,
    FINISH = 2'd2
  } muldiv_state_t;

  // One iteration per operand bit; must match the WIDTH of the unit.
  localparam int MULDIV_ITERS = 32;

endpackage

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit owning the architectural HI/LO pair.
// MULT/MULTU use a shift-add multiplier, DIV/DIVU a restoring divider;
// both work on operand magnitudes and share one double-width working
// register and one (WIDTH+1)-bit adder/subtractor. Signs are fixed up
// in the FINISH cycle before HI/LO are written.
//
// Ports:
//   CLK          clock, rising-edge
//   reset        asynchronous active-high reset, clears all state
//   start        request a new operation (sampled only while idle)
//   op           operation code, see muldiv_op_t
//   a, b         operands (rs / rt)
//   hi_we, lo_we MTHI / MTLO write enables (honoured only while idle)
//   wd           MTHI / MTLO write data
//   busy         operation in flight (registered)
//   done         one-cycle pulse after the result has been committed
//   hi, lo       architectural HI and LO registers
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wd,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int W2 = 2 * WIDTH;

  muldiv_state_t    state_q, state_d;
  muldiv_op_t       op_q, op_d;
  logic [WIDTH-1:0] magA_q, magA_d;
  logic [WIDTH-1:0] magB_q, magB_d;
  logic [WIDTH-1:0] rawA_q, rawA_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [W2-1:0]    work_q, work_d;
  logic [4:0]       cnt_q, cnt_d;
  logic             negRes_q, negRes_d;
  logic             negRem_q, negRem_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  muldiv_op_t       opIn;
  logic             inSigned;
  logic             inDiv;
  logic             isDiv;
  logic [WIDTH:0]   addA;
  logic [WIDTH:0]   addB;
  logic [WIDTH+1:0] addRes;
  logic [W2-1:0]    prodFix;
  logic [WIDTH-1:0] quotFix;
  logic [WIDTH-1:0] remFix;

  // Shared adder/subtractor. For multiply it adds the multiplicand into
  // the upper half of the accumulator; for divide it trial-subtracts the
  // divisor from the partial remainder shifted left by one (the top
  // WIDTH+1 bits of the working register). The extra MSB is the borrow.
  always_comb begin
    opIn     = muldiv_op_t'(op);
    inSigned = (opIn == MULT) || (opIn == DIV);
    inDiv    = (opIn == DIV) || (opIn == DIVU);
    isDiv    = (op_q == DIV) || (op_q == DIVU);
    addA     = isDiv ? work_q[W2-1:WIDTH-1] : {1'b0, work_q[W2-1:WIDTH]};
    addB     = {1'b0, isDiv ? magB_q : magA_q};
    addRes   = isDiv ? ({1'b0, addA} - {1'b0, addB})
                     : ({1'b0, addA} + {1'b0, addB});
  end

  // Sign correction applied in FINISH. The remainder follows the dividend
  // sign, the product and quotient are negated when operand signs differ.
  always_comb begin
    prodFix = negRes_q ? -work_q : work_q;
    quotFix = negRes_q ? -work_q[WIDTH-1:0] : work_q[WIDTH-1:0];
    remFix  = negRem_q ? -work_q[W2-1:WIDTH] : work_q[W2-1:WIDTH];
  end

  // Next-state logic for the controller and the datapath. In IDLE the
  // unit accepts MTHI/MTLO and a new operation in the same cycle; during
  // CALC one multiplier or quotient bit is resolved per cycle; FINISH
  // commits the corrected result to HI/LO and raises done.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    magA_d   = magA_q;
    magB_d   = magB_q;
    rawA_d   = rawA_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    work_d   = work_q;
    cnt_d    = cnt_q;
    negRes_d = negRes_q;
    negRem_d = negRem_q;
    busy_d   = busy_q;
    done_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (hi_we) hi_d = wd;
        if (lo_we) lo_d = wd;
        if (start) begin
          op_d     = opIn;
          magA_d   = (inSigned && a[WIDTH-1]) ? -a : a;
          magB_d   = (inSigned && b[WIDTH-1]) ? -b : b;
          rawA_d   = a;
          negRes_d = inSigned && (a[WIDTH-1] ^ b[WIDTH-1]);
          negRem_d = inSigned && a[WIDTH-1];
          // Multiply keeps the multiplier in the low half and shifts it
          // out as the product shifts in; divide keeps the dividend there
          // and shifts quotient bits in behind it.
          work_d   = inDiv ? {{WIDTH{1'b0}}, magA_d} : {{WIDTH{1'b0}}, magB_d};
          cnt_d    = 5'd0;
          busy_d   = 1'b1;
          state_d  = CALC;
        end
      end

      CALC: begin
        cnt_d = cnt_q + 5'd1;
        if (isDiv) begin
          // Borrow set means the shifted remainder is below the divisor:
          // keep it (restore) and shift in a 0 quotient bit.
          if (addRes[WIDTH+1]) begin
            work_d = {work_q[W2-2:0], 1'b0};
          end else begin
            work_d = {addRes[WIDTH-1:0], work_q[WIDTH-2:0], 1'b1};
          end
        end else begin
          if (work_q[0]) begin
            work_d = {addRes[WIDTH:0], work_q[WIDTH-1:1]};
          end else begin
            work_d = {1'b0, work_q[W2-1:1]};
          end
        end
        if (cnt_q == 5'(MULDIV_ITERS - 1)) state_d = FINISH;
      end

      FINISH: begin
        if (isDiv) begin
          // Divide by zero returns all ones and the untouched dividend.
          if (magB_q == '0) begin
            lo_d = '1;
            hi_d = rawA_q;
          end else begin
            lo_d = quotFix;
            hi_d = remFix;
          end
        end else begin
          hi_d = prodFix[W2-1:WIDTH];
          lo_d = prodFix[WIDTH-1:0];
        end
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State registers. Reset is asynchronous so an in-flight operation is
  // abandoned immediately and HI/LO read as zero from that moment.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      op_q     <= MULT;
      magA_q   <= '0;
      magB_q   <= '0;
      rawA_q   <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      work_q   <= '0;
      cnt_q    <= 5'd0;
      negRes_q <= 1'b0;
      negRem_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      magA_q   <= magA_d;
      magB_q   <= magB_d;
      rawA_q   <= rawA_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      work_q   <= work_d;
      cnt_q    <= cnt_d;
      negRes_q <= negRes_d;
      negRem_q <= negRem_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit. A behavioural model computes the
// expected HI/LO with plain integer arithmetic; directed cases cover the
// corner behaviour and a randomized batch covers general operands.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int WIDTH = 32;

  logic             CLK = 1'b0;
  logic             reset;
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wd;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  int checks = 0;
  int errors = 0;

  logic [31:0] expHi = '0;
  logic [31:0] expLo = '0;
  logic [31:0] specials [6];

  // Free-running clock, 10 time-unit period.
  always #5 CLK = ~CLK;

  muldiv_unit #(.WIDTH(WIDTH)) dut (
    .CLK   (CLK),
    .reset (reset),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .hi_we (hi_we),
    .lo_we (lo_we),
    .wd    (wd),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  // Reference result as {HI, LO} computed with 64-bit integer arithmetic.
  function automatic logic [63:0] refModel(input logic [1:0] o, input logic [31:0] x,
                                           input logic [31:0] y);
    longint          sx, sy, q, m;
    longint unsigned ux, uy;
    logic [63:0]     r;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'b0, x};
    uy = {32'b0, y};
    r  = '0;
    case (o)
      2'd0: r = sx * sy;
      2'd1: r = ux * uy;
      2'd2: begin
        if (y == 32'h0) r = {x, 32'hFFFF_FFFF};
        else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) r = {32'h0, 32'h8000_0000};
        else begin
          q = sx / sy;
          m = sx % sy;
          r = {m[31:0], q[31:0]};
        end
      end
      default: begin
        if (y == 32'h0) r = {x, 32'hFFFF_FFFF};
        else r = {32'(ux % uy), 32'(ux / uy)};
      end
    endcase
    return r;
  endfunction

  // One comparison point: count it, and report and count any difference.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Issue one operation and follow it to completion. Optional extras:
  // a stray start mid-operation, MTHI/MTLO attempts while busy, and an
  // MTHI issued in the same cycle as start.
  task automatic applyStimulus(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                               input bit midStart, input bit midHiWe, input bit issueHiWe,
                               input logic [31:0] wdVal);
    logic [63:0] res;
    int          doneAt;
    int          busyCnt;
    res = refModel(o, x, y);
    @(negedge CLK);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    if (issueHiWe) begin
      hi_we = 1'b1;
      wd    = wdVal;
    end
    @(posedge CLK);
    #1;
    start = 1'b0;
    hi_we = 1'b0;
    a     = $urandom;
    b     = $urandom;
    if (issueHiWe) begin
      expHi = wdVal;
      checkOutput("issue_hi_we", {32'b0, hi}, {32'b0, expHi});
    end
    checkOutput("busy_issue", {63'b0, busy}, 64'd1);
    busyCnt = busy ? 1 : 0;
    doneAt  = 0;
    for (int k = 1; k <= 40 && doneAt == 0; k++) begin
      @(posedge CLK);
      #1;
      if (busy) busyCnt++;
      if (done) doneAt = k;
      if (k == 5 && midStart) begin
        start = 1'b1;
        op    = ~o;
        a     = $urandom;
        b     = $urandom;
      end
      if (k == 6) start = 1'b0;
      if (k == 10 && midHiWe) begin
        hi_we = 1'b1;
        lo_we = 1'b1;
        wd    = $urandom;
      end
      if (k == 11) begin
        hi_we = 1'b0;
        lo_we = 1'b0;
      end
      if (k == 20) begin
        checkOutput("hold_hi", {32'b0, hi}, {32'b0, expHi});
        checkOutput("hold_lo", {32'b0, lo}, {32'b0, expLo});
      end
    end
    checkOutput("done_latency", 64'(doneAt), 64'd33);
    checkOutput("busy_cycles", 64'(busyCnt), 64'd33);
    expHi = res[63:32];
    expLo = res[31:0];
    checkOutput("result_hi", {32'b0, hi}, {32'b0, expHi});
    checkOutput("result_lo", {32'b0, lo}, {32'b0, expLo});
    @(posedge CLK);
    #1;
    checkOutput("done_pulse", {63'b0, done}, 64'd0);
  endtask

  // Directed sequence followed by a randomized batch.
  initial begin
    specials[0] = 32'h0000_0000;
    specials[1] = 32'h0000_0001;
    specials[2] = 32'hFFFF_FFFF;
    specials[3] = 32'h8000_0000;
    specials[4] = 32'h7FFF_FFFF;
    specials[5] = 32'h0000_0002;

    reset = 1'b1;
    start = 1'b0;
    op    = 2'd0;
    a     = '0;
    b     = '0;
    hi_we = 1'b0;
    lo_we = 1'b0;
    wd    = '0;
    #1;
    checkOutput("reset_busy", {63'b0, busy}, 64'd0);
    checkOutput("reset_done", {63'b0, done}, 64'd0);
    checkOutput("reset_hi", {32'b0, hi}, 64'd0);
    checkOutput("reset_lo", {32'b0, lo}, 64'd0);
    @(negedge CLK);
    @(negedge CLK);
    reset = 1'b0;

    applyStimulus(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, '0);
    checkOutput("multu_max_hi", {32'b0, hi}, 64'hFFFF_FFFE);
    checkOutput("multu_max_lo", {32'b0, lo}, 64'h0000_0001);
    applyStimulus(2'd0, 32'hFFFF_FFFF, 32'h0000_0002, 1'b0, 1'b0, 1'b0, '0);
    applyStimulus(2'd3, 32'd7, 32'd2, 1'b0, 1'b0, 1'b0, '0);
    applyStimulus(2'd2, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0, 1'b0, '0);
    checkOutput("div_neg_lo", {32'b0, lo}, 64'hFFFF_FFFD);
    applyStimulus(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, '0);
    applyStimulus(2'd3, 32'h0000_1234, 32'h0, 1'b1, 1'b0, 1'b0, '0);
    applyStimulus(2'd2, 32'h8765_4321, 32'h0, 1'b0, 1'b0, 1'b0, '0);

    // MTLO while idle lands at the next edge; HI is untouched.
    @(negedge CLK);
    lo_we = 1'b1;
    wd    = 32'hA5A5_A5A5;
    @(posedge CLK);
    #1;
    lo_we = 1'b0;
    expLo = 32'hA5A5_A5A5;
    checkOutput("mtlo_lo", {32'b0, lo}, {32'b0, expLo});
    checkOutput("mtlo_hi", {32'b0, hi}, {32'b0, expHi});

    applyStimulus(2'd1, 32'h0001_0003, 32'h0002_0005, 1'b0, 1'b1, 1'b0, '0);
    applyStimulus(2'd0, 32'd3, 32'hFFFF_FFFB, 1'b0, 1'b0, 1'b1, 32'h5A5A_1234);

    // Reset in the middle of a divide abandons it at once.
    @(negedge CLK);
    start = 1'b1;
    op    = 2'd2;
    a     = 32'h1234_5678;
    b     = 32'h0000_0013;
    @(posedge CLK);
    #1;
    start = 1'b0;
    repeat (10) @(posedge CLK);
    #1;
    reset = 1'b1;
    #1;
    expHi = '0;
    expLo = '0;
    checkOutput("midreset_busy", {63'b0, busy}, 64'd0);
    checkOutput("midreset_hi", {32'b0, hi}, 64'd0);
    checkOutput("midreset_lo", {32'b0, lo}, 64'd0);
    @(negedge CLK);
    reset = 1'b0;
    applyStimulus(2'd1, 32'd3, 32'd5, 1'b0, 1'b0, 1'b0, '0);
    checkOutput("after_reset_lo", {32'b0, lo}, 64'd15);

    for (int i = 0; i < 24; i++) begin
      logic [1:0]  rOp;
      logic [31:0] rA;
      logic [31:0] rB;
      rOp = 2'($urandom_range(0, 3));
      rA  = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 5)] : $urandom;
      rB  = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 5)] : $urandom;
      if ($urandom_range(0, 3) == 0) rB = rB >> $urandom_range(1, 31);
      applyStimulus(rOp, rA, rB, 1'b0, 1'b0, 1'b0, '0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Guard against a hung run.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog observed=timeout expected=completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide unit owning the HI/LO register pair. Sits directly downstream of the register file and takes its two read ports, rs → `a` and rt → `b`, as operands. Executes MULT, MULTU, DIV and DIVU over multiple cycles and signals `busy` so the controller stalls. Also services MTHI/MTLO direct writes and drives HI/LO for MFHI/MFLO.

## Interface
Parameters:
- `WIDTH`, 32, operand and HI/LO width.

Ports:
- `CLK`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `start`  in  1  request a new operation; sampled only in IDLE.
- `op`  in  2  operation, decoded via `muldiv_pkg`: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU.
- `a`  in  WIDTH  multiplicand / dividend, from register-file `rd1`.
- `b`  in  WIDTH  multiplier / divisor, from register-file `rd2`.
- `hi_we`, `lo_we`  in  1 each  MTHI / MTLO write enables.
- `wd`  in  WIDTH  data for MTHI / MTLO.
- `busy`  out  1  an operation is in flight; reset 0.
- `done`  out  1  one-cycle pulse when the result is committed; reset 0.
- `hi`, `lo`  out  WIDTH  architectural HI and LO; reset 0.

## Operation
- States: IDLE, CALC, FINISH.
- IDLE with `start`=1:
  - Latch `op`.
  - Latch operand magnitudes: absolute value for signed ops, raw value for unsigned.
  - Latch the result-sign flags.
  - Clear the 5-bit iteration counter and go to CALC.
- CALC: one iteration per cycle, 32 cycles.
  - Multiply: shift-add into a 64-bit accumulator.
  - Divide: restoring division, one quotient bit per cycle.
  - When the counter reaches 31, go to FINISH.
- FINISH:
  - Apply sign correction.
    - Signed product is negated when the signs of `a` and `b` differ.
    - Signed quotient is negated when the signs differ.
    - Signed remainder takes the sign of `a`.
  - Write HI/LO, pulse `done`, return to IDLE.
- Result mapping:
  - Multiply: HI = product[63:32], LO = product[31:0].
  - Divide: LO = quotient, HI = remainder.
- Divide by zero: LO = all ones, HI = `a` (raw value), for both DIV and DIVU.
- Signed overflow, 0x8000_0000 / -1: LO = 0x8000_0000, HI = 0. Nothing traps.
- MTHI/MTLO:
  - Honoured only in IDLE; `hi_we`/`lo_we` write `wd` at that edge.
  - Ignored in CALC/FINISH; the controller must stall them behind `busy`.
- `start` in IDLE together with `hi_we`/`lo_we`: both are accepted. The direct write lands now; the operation result overwrites HI/LO at FINISH.
- `start` while `busy`: ignored. Operands are not re-sampled.
- HI/LO keep their value during CALC. Old values stay readable until commit.
- `reset` asserted at any time, including mid-operation:
  - Go to IDLE immediately.
  - `busy`=0, `done`=0, `hi`=`lo`=0, counter=0.
  - The partial result is discarded.

## Timing
- `start` sampled at rising edge N.
  - CALC covers edges N+1 … N+32.
  - FINISH is the cycle after edge N+32.
  - HI/LO update at edge N+33.
  - `done`=1 for exactly the cycle after edge N+33.
- `busy` is high from edge N through edge N+33 (33 cycles) and low in the `done` cycle. A back-to-back `start` is therefore accepted at edge N+34.
- `busy` is registered, never combinational from `start`. The controller stalls on `start` itself in the issue cycle.
- `hi`/`lo` are registered outputs with no combinational path from `a`/`b`/`wd`.
- The register file writes on the falling edge. Operands driven from `rd1`/`rd2` are stable at the rising edge that samples `start`.

## Structure
- `muldiv_pkg` holds:
  - `muldiv_op_t` enum (MULT, MULTU, DIV, DIVU, 2 bits).
  - `muldiv_state_t` enum (IDLE, CALC, FINISH).
  - `MULDIV_ITERS` = 32.
- No sub-module. The shift-add and restoring-divide steps share one 64-bit working register and a 33-bit adder/subtractor inside `muldiv_unit`.

## Test plan
- Reset, then MULTU a=0xFFFF_FFFF, b=0xFFFF_FFFF → after 33 edges HI=0xFFFF_FFFE, LO=0x0000_0001, `done` for one cycle, `busy` 33 cycles.
- MULT a=0xFFFF_FFFF (-1), b=2 → HI=0xFFFF_FFFF, LO=0xFFFF_FFFE. DIVU 7/2 → LO=3, HI=1.
- DIV a=-7 (0xFFFF_FFF9), b=2 → LO=0xFFFF_FFFD, HI=0xFFFF_FFFF. DIV 0x8000_0000 / 0xFFFF_FFFF → LO=0x8000_0000, HI=0.
- DIVU a=0x1234, b=0 → LO=0xFFFF_FFFF, HI=0x1234. A second `start` pulsed mid-operation is ignored: result and latency are unchanged.
- MTLO wd=0xA5A5_A5A5 in IDLE → `lo`=0xA5A5_A5A5 next edge. `hi_we` during `busy` → HI unchanged. `start`+`hi_we` together → HI first =`wd`, then the product at commit.
- Assert `reset` at cycle 10 of a DIV → `busy`=0, `hi`=`lo`=0 immediately. A new MULTU 3×5 started afterwards gives LO=15, HI=0.
